// File: rtl/trap_bank_unit_pkg.sv
// Shared types and constants for the trap/bank register unit.
package trap_bank_unit_pkg;

    localparam int unsigned BANKS       = 4;
    localparam int unsigned BANK_W      = 8;
    localparam int unsigned FIFO_DEPTH  = 2;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned BANK_IDX_W  = $clog2(BANKS);
    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned STAT_W      = 4;

    // trap_status bit positions
    localparam int unsigned TRAP_STAT_OVF    = 3;
    localparam int unsigned TRAP_STAT_DIR    = 2;
    localparam int unsigned TRAP_STAT_CNT_HI = 1;
    localparam int unsigned TRAP_STAT_CNT_LO = 0;

    localparam logic [DATA_W-1:0] EMPTY_READ_BYTE = 8'hFF;

    // One trapped I/O violation: direction (1 = OUT) and full address
    typedef struct packed {
        logic              dir;
        logic [ADDR_W-1:0] addr;
    } trap_entry_t;

endpackage

// File: rtl/trap_bank_unit_if.sv
// Z80-side bus between the mapper decode and the trap/bank unit.
// master: CPU/decode side driving strobes, address and write data.
// slave : trap_bank_unit returning read data, translated page and status.
interface trap_bank_unit_if #(
    parameter int unsigned BANK_W = 8
);
    logic [7:0]        data_in;
    logic [7:0]        data_out;
    logic              data_oe;
    logic [15:0]       cpu_addr;
    logic [2:0]        lo_addr;
    logic              io_direction;
    logic              bank_wr_n;
    logic              trap_addr_wr_n;
    logic              trap_addr_rd_n;
    logic              trans_addr;
    logic [BANK_W-1:0] mapped_hi;
    logic [3:0]        trap_status;

    modport master (
        output data_in, cpu_addr, lo_addr, io_direction,
               bank_wr_n, trap_addr_wr_n, trap_addr_rd_n, trans_addr,
        input  data_out, data_oe, mapped_hi, trap_status
    );

    modport slave (
        input  data_in, cpu_addr, lo_addr, io_direction,
               bank_wr_n, trap_addr_wr_n, trap_addr_rd_n, trans_addr,
        output data_out, data_oe, mapped_hi, trap_status
    );
endinterface

// File: rtl/trap_bank_unit_strobe_sync.sv
// Synchroniser + edge detector for one asynchronous active-low strobe.
// Ports: clk, reset (sync, active-high), in_n (raw strobe),
//        assert_evt (synced 1->0), release_evt (synced 0->1), level (synced value).
module trap_bank_unit_strobe_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic in_n,
    output logic assert_evt,
    output logic release_evt,
    output logic level
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] valid_q;
    logic                   prev_q;
    logic                   armed_q;

    // valid_q marks when sync_q holds real post-reset samples; events are only
    // armed once a genuine high level has been seen, so a strobe held low
    // across reset stays silent until it releases and re-asserts.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '1;
            valid_q <= '0;
            prev_q  <= 1'b1;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], in_n};
            valid_q <= {valid_q[SYNC_STAGES-2:0], 1'b1};
            prev_q  <= sync_q[SYNC_STAGES-1];
            if (valid_q[SYNC_STAGES-1] && sync_q[SYNC_STAGES-1]) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign level       = sync_q[SYNC_STAGES-1];
    assign assert_evt  = armed_q &  prev_q & ~level;
    assign release_evt = armed_q & ~prev_q &  level;

endmodule

// File: rtl/trap_bank_unit.sv
// Bank register file for 16K-page translation plus a trapped-I/O address FIFO
// read back byte-wise by the trap handler.
// Ports: clk, reset (sync, active-high), bus (slave side of trap_bank_unit_if:
//        Z80 strobes/address/data in; data_out/data_oe, mapped_hi, trap_status out).
module trap_bank_unit
    import trap_bank_unit_pkg::*;
#(
    parameter int unsigned BANKS_P       = BANKS,
    parameter int unsigned BANK_W_P      = BANK_W,
    parameter int unsigned FIFO_DEPTH_P  = FIFO_DEPTH,
    parameter int unsigned SYNC_STAGES_P = SYNC_STAGES
) (
    input  logic     clk,
    input  logic     reset,
    trap_bank_unit_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(BANKS_P);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH_P);

    logic bank_evt, bank_rel, bank_lvl;
    logic twr_evt, twr_rel, twr_lvl;
    logic trd_evt, trd_rel, trd_lvl;

    trap_bank_unit_strobe_sync #(.SYNC_STAGES(SYNC_STAGES_P)) u_sync_bank (
        .clk(clk), .reset(reset), .in_n(bus.bank_wr_n),
        .assert_evt(bank_evt), .release_evt(bank_rel), .level(bank_lvl)
    );
    trap_bank_unit_strobe_sync #(.SYNC_STAGES(SYNC_STAGES_P)) u_sync_twr (
        .clk(clk), .reset(reset), .in_n(bus.trap_addr_wr_n),
        .assert_evt(twr_evt), .release_evt(twr_rel), .level(twr_lvl)
    );
    trap_bank_unit_strobe_sync #(.SYNC_STAGES(SYNC_STAGES_P)) u_sync_trd (
        .clk(clk), .reset(reset), .in_n(bus.trap_addr_rd_n),
        .assert_evt(trd_evt), .release_evt(trd_rel), .level(trd_lvl)
    );

    logic unused_ok_c;
    assign unused_ok_c = ^{bank_rel, bank_lvl, twr_rel, twr_lvl, trd_lvl, bus.lo_addr[2:1]};

    logic [BANK_W_P-1:0] bank_q [BANKS_P];
    trap_entry_t         fifo_q [FIFO_DEPTH_P];
    logic [PTR_W:0]      wr_ptr_q, rd_ptr_q;
    logic                ovf_q;
    logic                rd_hi_q;

    logic [PTR_W:0] count_c;
    logic           empty_c, full_c, pop_c, push_c, drop_c;
    trap_entry_t    head_c;
    logic [1:0]     cnt_sat_c;
    logic [3:0]     stat_c;

    // FIFO occupancy and push/pop arbitration; a pop on the same clk frees room for a push
    always_comb begin
        count_c   = wr_ptr_q - rd_ptr_q;
        empty_c   = (wr_ptr_q == rd_ptr_q);
        full_c    = (count_c == (PTR_W+1)'(FIFO_DEPTH_P));
        head_c    = fifo_q[rd_ptr_q[PTR_W-1:0]];
        pop_c     = trd_rel && rd_hi_q && !empty_c;
        push_c    = twr_evt && (!full_c || pop_c);
        drop_c    = twr_evt && full_c && !pop_c;
        cnt_sat_c = (32'(count_c) > 32'd3) ? 2'd3 : count_c[1:0];
        stat_c    = '0;
        stat_c[TRAP_STAT_OVF] = ovf_q;
        stat_c[TRAP_STAT_DIR] = !empty_c && head_c.dir;
        stat_c[TRAP_STAT_CNT_HI:TRAP_STAT_CNT_LO] = cnt_sat_c;
    end

    // Bank file, FIFO pointers, sticky overflow and latched read byte select
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(BANKS_P); i++) begin
                bank_q[i] <= BANK_W_P'(i);
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            rd_hi_q  <= 1'b0;
        end else begin
            if (bank_evt) begin
                bank_q[bus.lo_addr[IDX_W-1:0]] <= BANK_W_P'(bus.data_in);
            end
            if (trd_evt) begin
                rd_hi_q <= bus.lo_addr[0];
            end
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
            end
            if (drop_c) begin
                ovf_q <= 1'b1;
            end else if (pop_c && !push_c && count_c == (PTR_W+1)'(1)) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // FIFO storage needs no reset; pointers define validity
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_q[wr_ptr_q[PTR_W-1:0]] <= '{dir: bus.io_direction, addr: bus.cpu_addr};
        end
    end

    assign bus.mapped_hi   = bus.trans_addr ? bank_q[bus.cpu_addr[15 -: IDX_W]]
                                            : BANK_W_P'(bus.cpu_addr[15 -: IDX_W]);
    assign bus.data_out    = empty_c ? EMPTY_READ_BYTE
                           : (rd_hi_q ? head_c.addr[15:8] : head_c.addr[7:0]);
    assign bus.data_oe     = !bus.trap_addr_rd_n;
    assign bus.trap_status = stat_c;

endmodule
